// File: rtl/alu_seq_pkg.sv
// Shared opcode/state encodings for the sequential ALU (alu_seq).
// ALU_SEQ_MULDIV_EN selects whether the iterative opcodes are live.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd6,
    OP_SLTU = 4'd7,
    OP_MULU = 4'd8,
    OP_DIVU = 4'd9,
    OP_REMU = 4'd10,
    OP_NOR  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // One bit per opcode; set for MULU/DIVU/REMU (codes 8..10).
  localparam logic [15:0] ALU_OP_IS_ITER = 16'h0700;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the execute stage and alu_seq.
interface alu_seq_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_o;
  logic [W-1:0] alu_hi;
  logic         cout;
  logic         zero;
  logic         err;

  modport master (
    output in_valid, a, b, alu_ctrl, out_ready,
    input  in_ready, out_valid, alu_o, alu_hi, cout, zero, err
  );

  modport slave (
    input  in_valid, a, b, alu_ctrl, out_ready,
    output in_ready, out_valid, alu_o, alu_hi, cout, zero, err
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// W-step shift-add multiplier and restoring divider shared on one register pair.
// Only instantiated when ALU_SEQ_MULDIV_EN is defined.
module alu_muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  alu_op_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         dbz,
  output logic         done
);

  localparam int CW = $clog2(W);

  logic          busy;
  logic [CW-1:0] cnt;
  alu_op_e       op_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  acc_hi;
  logic [W-1:0]  acc_lo;
  logic [W:0]    mul_sum;
  logic [W:0]    div_sh;
  logic [W-1:0]  div_diff;
  logic          div_ge;

  // Multiply: {acc_hi, acc_lo} is partial product over the remaining multiplier bits.
  // Divide: acc_hi is the running remainder, acc_lo shifts dividend out and quotient in.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_r} : '0);
  assign div_sh   = {acc_hi, acc_lo[W-1]};
  assign div_ge   = div_sh >= {1'b0, b_r};
  assign div_diff = div_sh[W-1:0] - b_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(W - 1);
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      op_r   <= op;
      b_r    <= b;
      acc_hi <= '0;
      acc_lo <= a;
    end else if (busy) begin
      if (op_r == OP_MULU) begin
        acc_hi <= mul_sum[W:1];
        acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
      end else begin
        acc_hi <= div_ge ? div_diff : div_sh[W-1:0];
        acc_lo <= {acc_lo[W-2:0], div_ge};
      end
    end
  end

  // done flags the final step; the result registers are frozen after it.
  assign done = busy && (cnt == '0);
  assign lo   = (op_r == OP_REMU) ? acc_hi : acc_lo;
  assign hi   = (op_r == OP_MULU) ? acc_hi : '0;
  assign dbz  = (op_r != OP_MULU) && (b_r == '0);

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/add/sub/compare plus optional
// iterative MULU/DIVU/REMU enabled by ALU_SEQ_MULDIV_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] BUSY = ST_BUSY;
  localparam logic [1:0] DONE = ST_DONE;

  // Packed as {err, cout, result}; unknown opcodes give result 0 and err.
  function automatic logic [W+1:0] calc(input logic [3:0] op,
                                        input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         e;
    s = '0;
    r = '0;
    c = 1'b0;
    e = 1'b0;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0];
        c = s[W];
      end
      OP_SUB: begin
        r = x - y;
        c = x < y;
      end
      OP_SLTU: r = {{(W-1){1'b0}}, (x < y)};
      OP_NOR:  r = ~(x | y);
      default: e = 1'b1;
    endcase
    return {e, c, r};
  endfunction

  logic [1:0]   state;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         sel_eng;
  logic [W-1:0] res_lo;
  logic         res_cout;
  logic         res_zero;
  logic         res_err;
  logic         accept;
  logic         iter_go;
  logic [W+1:0] sc;
  logic [W-1:0] eng_lo;
  logic [W-1:0] eng_hi;
  logic         eng_dbz;
  logic         eng_done;

  assign accept = (state == IDLE) && in_ready_r && bus.in_valid;
  assign sc     = calc(bus.alu_ctrl, bus.a, bus.b);

`ifdef ALU_SEQ_MULDIV_EN
  assign iter_go = accept && ALU_OP_IS_ITER[bus.alu_ctrl];

  alu_muldiv_iter #(.W(W)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (iter_go),
    .op    (alu_op_e'(bus.alu_ctrl)),
    .a     (bus.a),
    .b     (bus.b),
    .lo    (eng_lo),
    .hi    (eng_hi),
    .dbz   (eng_dbz),
    .done  (eng_done)
  );
`else
  assign iter_go  = 1'b0;
  assign eng_lo   = '0;
  assign eng_hi   = '0;
  assign eng_dbz  = 1'b0;
  assign eng_done = 1'b0;
`endif

  // in_ready is a register so it stays low for the cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      sel_eng     <= 1'b0;
      res_lo      <= '0;
      res_cout    <= 1'b0;
      res_zero    <= 1'b0;
      res_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready_r <= 1'b0;
            sel_eng    <= 1'b0;
            if (iter_go) begin
              state <= BUSY;
            end else begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              res_lo      <= sc[W-1:0];
              res_cout    <= sc[W];
              res_err     <= sc[W+1];
              res_zero    <= (sc[W-1:0] == '0);
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        BUSY: begin
          if (eng_done) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            sel_eng     <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Iterative results are read straight from the frozen engine registers.
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.alu_o     = sel_eng ? eng_lo : res_lo;
  assign bus.alu_hi    = sel_eng ? eng_hi : '0;
  assign bus.cout      = sel_eng ? 1'b0 : res_cout;
  assign bus.zero      = sel_eng ? (eng_lo == '0) : res_zero;
  assign bus.err       = sel_eng ? eng_dbz : res_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random bench for alu_seq (W=8); follows ALU_SEQ_MULDIV_EN like the RTL.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_seq_if #(.W(8)) bus();

  alu_seq #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_asrt = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                          input logic c, input logic z, input logic e);
    chk({tag, " alu_o"},  32'(bus.alu_o),  32'(lo));
    chk({tag, " alu_hi"}, 32'(bus.alu_hi), 32'(hi));
    chk({tag, " cout"},   32'(bus.cout),   32'(c));
    chk({tag, " zero"},   32'(bus.zero),   32'(z));
    chk({tag, " err"},    32'(bus.err),    32'(e));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    chk_outs(tag, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk("in_ready wait", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat, input logic [7:0] e_lo,
                        input logic [7:0] e_hi, input logic e_c, input logic e_z,
                        input logic e_e);
    int   lat;
    logic ir_seen;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.alu_ctrl = op;
    bus.a        = a;
    bus.b        = b;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = ~b;
    bus.alu_ctrl = 4'd2;
    lat     = 1;
    ir_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      ir_seen = ir_seen | bus.in_ready;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " in_ready low"}, 32'(ir_seen | bus.in_ready), 32'd0);
    chk_outs(tag, e_lo, e_hi, e_c, e_z, e_e);
  endtask

  function automatic void ref_model(input logic [3:0] op, input logic [7:0] a,
                                    input logic [7:0] b, output logic [7:0] lo,
                                    output logic [7:0] hi, output logic c,
                                    output logic z, output logic e, output int lat);
    logic [8:0]  s;
    logic [15:0] p;
    lo = 8'd0; hi = 8'd0; c = 1'b0; e = 1'b0; lat = 1;
    s = 9'd0; p = 16'd0;
    case (op)
      4'd0:  lo = a & b;
      4'd1:  lo = a | b;
      4'd2:  begin s = {1'b0, a} + {1'b0, b}; lo = s[7:0]; c = s[8]; end
      4'd6:  begin lo = a - b; c = (a < b); end
      4'd7:  lo = (a < b) ? 8'd1 : 8'd0;
      4'd12: lo = ~(a | b);
`ifdef ALU_SEQ_MULDIV_EN
      4'd8:  begin p = {8'd0, a} * {8'd0, b}; lo = p[7:0]; hi = p[15:8]; lat = 9; end
      4'd9:  begin lo = (b == 0) ? 8'hFF : a / b; e = (b == 0); lat = 9; end
      4'd10: begin lo = (b == 0) ? a : a % b; e = (b == 0); lat = 9; end
`endif
      default: e = 1'b1;
    endcase
    z = (lo == 8'd0);
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops[$];
    logic [3:0] op;
    logic [7:0] ra, rb, elo, ehi;
    logic       ec, ez, ee;
    int         elat;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a        = 8'd0;
    bus.b        = 8'd0;
    bus.alu_ctrl = 4'd0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    run_op("add 200+100", 4'd2, 8'd200, 8'd100, 1, 8'd44, 8'd0, 1'b1, 1'b0, 1'b0);
    run_op("sub 5-5",     4'd6, 8'd5,   8'd5,   1, 8'd0,  8'd0, 1'b0, 1'b1, 1'b0);
    run_op("sub 3-7",     4'd6, 8'd3,   8'd7,   1, 8'd252, 8'd0, 1'b1, 1'b0, 1'b0);
    run_op("add 255+1",   4'd2, 8'd255, 8'd1,   1, 8'd0,  8'd0, 1'b1, 1'b1, 1'b0);
    run_op("and",         4'd0, 8'hF0,  8'h3C,  1, 8'h30, 8'd0, 1'b0, 1'b0, 1'b0);
    run_op("or",          4'd1, 8'hF0,  8'h3C,  1, 8'hFC, 8'd0, 1'b0, 1'b0, 1'b0);
    run_op("nor",         4'd12, 8'hF0, 8'h0C,  1, 8'h03, 8'd0, 1'b0, 1'b0, 1'b0);
    run_op("nor to zero", 4'd12, 8'hFF, 8'h00,  1, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0);
    run_op("sltu 3<7",    4'd7, 8'd3,   8'd7,   1, 8'd1,  8'd0, 1'b0, 1'b0, 1'b0);
    run_op("sltu 7<3",    4'd7, 8'd7,   8'd3,   1, 8'd0,  8'd0, 1'b0, 1'b1, 1'b0);
    run_op("illegal 3",   4'd3, 8'd9,   8'd4,   1, 8'd0,  8'd0, 1'b0, 1'b1, 1'b1);
    run_op("illegal 15",  4'd15, 8'd1,  8'd1,   1, 8'd0,  8'd0, 1'b0, 1'b1, 1'b1);

`ifdef ALU_SEQ_MULDIV_EN
    run_op("mulu 255*255", 4'd8,  8'd255, 8'd255, 9, 8'd1,   8'd254, 1'b0, 1'b0, 1'b0);
    run_op("mulu 0*5",     4'd8,  8'd0,   8'd5,   9, 8'd0,   8'd0,   1'b0, 1'b1, 1'b0);
    run_op("divu 100/7",   4'd9,  8'd100, 8'd7,   9, 8'd14,  8'd0,   1'b0, 1'b0, 1'b0);
    run_op("remu 100%7",   4'd10, 8'd100, 8'd7,   9, 8'd2,   8'd0,   1'b0, 1'b0, 1'b0);
    run_op("divu 9/0",     4'd9,  8'd9,   8'd0,   9, 8'd255, 8'd0,   1'b0, 1'b0, 1'b1);
    run_op("remu 9%0",     4'd10, 8'd9,   8'd0,   9, 8'd9,   8'd0,   1'b0, 1'b0, 1'b1);
`else
    run_op("mulu disabled", 4'd8,  8'd255, 8'd255, 1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    run_op("divu disabled", 4'd9,  8'd100, 8'd7,   1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    run_op("remu disabled", 4'd10, 8'd100, 8'd7,   1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
`endif

    // Backpressure: result must hold while a competing request waits.
    wait_ready();
    bus.out_ready = 1'b0;
    run_op("bp add 17+25", 4'd2, 8'd17, 8'd25, 1, 8'd42, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 4'd1;
      bus.a        = 8'd1;
      bus.b        = 8'd2;
      tick();
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp alu_o",     32'(bus.alu_o),     32'd42);
      chk("bp in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp consume out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp consume in_ready",  32'(bus.in_ready),  32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp next out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp next alu_o",     32'(bus.alu_o),     32'd3);

    // Reset while a result is held in DONE.
    wait_ready();
    bus.out_ready = 1'b0;
    run_op("pre-rst add", 4'd2, 8'd200, 8'd100, 1, 8'd44, 8'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_all_zero("rst in done");
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("rst in done in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst in done out_valid", 32'(bus.out_valid), 32'd0);

`ifdef ALU_SEQ_MULDIV_EN
    // Reset in the 4th BUSY cycle of a multiply.
    wait_ready();
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 4'd8;
    bus.a        = 8'd255;
    bus.b        = 8'd255;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("rst in busy");
    rst = 1'b0;
    tick();
    chk("rst in busy in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst in busy out_valid", 32'(bus.out_valid), 32'd0);
    run_op("mulu after rst", 4'd8, 8'd12, 8'd11, 9, 8'd132, 8'd0, 1'b0, 1'b0, 1'b0);
`endif

    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
`ifdef ALU_SEQ_MULDIV_EN
    ops.push_back(4'd8);
    ops.push_back(4'd9);
    ops.push_back(4'd10);
`endif
    for (int i = 0; i < 1000; i++) begin
      op = ops[$urandom_range(0, ops.size() - 1)];
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rb = 8'd0;
      ref_model(op, ra, rb, elo, ehi, ec, ez, ee, elat);
      run_op($sformatf("rand%0d op%0d a%0d b%0d", i, op, ra, rb), op, ra, rb, elat,
             elo, ehi, ec, ez, ee);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the processor's single-cycle 8-bit ALU. Keeps the existing `alu_ctrl` encoding and result flags. Adds iterative unsigned multiply, divide and remainder, plus valid/ready flow control on both sides. Sits in the execute stage: the pipeline stalls on `in_ready` and consumes results on `out_valid`/`out_ready`.

## Interface
- `W`, 8: operand and result width; must be ≥ 2.
- `clk`  in  1: clock; everything is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: operands and opcode are valid.
- `in_ready`  out  1: block accepts a new operation.
- `a`, `b`  in  W: operands, treated as unsigned.
- `alu_ctrl`  in  4: opcode.
- `out_valid`  out  1: result is valid.
- `out_ready`  in  1: consumer takes the result.
- `alu_o`  out  W: result, or the low half of a product.
- `alu_hi`  out  W: high half of a product; 0 for every other op.
- `cout`  out  1: carry (ADD) or borrow (SUB); 0 for every other op.
- `zero`  out  1: `alu_o == 0`.
- `err`  out  1: illegal opcode, or divide by zero.

## Operation
- Opcodes:
  - 0: AND.
  - 1: OR.
  - 2: ADD; `{cout, alu_o} = a + b`.
  - 6: SUB; `alu_o = (a - b) mod 2^W`, `cout = (a < b)`.
  - 7: SLTU; `alu_o = {W-1 zeros, a < b}`.
  - 12: NOR.
  - 8: MULU; `{alu_hi, alu_o} = a * b`, full 2W-bit product.
  - 9: DIVU; `alu_o = a / b`.
  - 10: REMU; `alu_o = a % b`.
- Any other code: `alu_o = 0`, `zero = 1`, `err = 1`, single-cycle latency.
- Divide by zero:
  - DIVU returns all ones; REMU returns `a`.
  - `err = 1` in both cases; takes the full iterative latency.
- FSM states are IDLE, BUSY and DONE.
  - IDLE: `in_ready = 1`. Accept occurs when `in_valid && in_ready`; operands and opcode are latched on that edge.
  - Accepted single-cycle op or illegal op: go to DONE.
  - Accepted MULU/DIVU/REMU: go to BUSY with the iteration counter set to `W-1`.
  - BUSY: one shift-add or restoring-subtract step per cycle. When the counter reaches 0, go to DONE.
  - DONE: `out_valid = 1` and the result outputs are held stable. On `out_ready`, go to IDLE.
- `in_ready` is 0 in BUSY and in DONE. A new op is never accepted in the same cycle a result is consumed.
- Inputs are ignored outside the accept edge; changing `a`/`b` while BUSY has no effect.
- `rst` high in any state, including mid-iteration:
  - Next state is IDLE and any partial result is discarded.
  - All outputs are 0, including `in_ready`, while `rst` is sampled high.
- Reset values: `in_ready = 0`, `out_valid = 0`, `alu_o = 0`, `alu_hi = 0`, `cout = 0`, `zero = 0`, `err = 0`.
- `in_ready` rises to 1 in the first cycle after `rst` falls.

## Timing
- Latency is counted from the accept edge to the first cycle in which `out_valid` is high.
  - Single-cycle and illegal ops: 1 cycle.
  - MULU/DIVU/REMU: W+1 cycles (W iterations plus the DONE transition).
- Peak throughput:
  - One single-cycle op every 2 cycles when `out_ready` is tied high.
  - One iterative op every W+2 cycles.
- Backpressure: DONE may last any number of cycles and all outputs stay constant throughout.
- All outputs are registered or decoded from the registered state only. There is no combinational path from an input to an output.

## Configuration
- Macro: `ALU_SEQ_MULDIV_EN`.
- Defined: opcodes 8/9/10 behave as above, and the iterative engine is instantiated.
- Undefined:
  - No engine is instantiated and BUSY is never entered.
  - Opcodes 8/9/10 are treated as illegal: `err = 1`, `alu_o = 0`, 1-cycle latency.

## Structure
- Package `alu_seq_pkg` holds:
  - `alu_op_e`: enum of all opcodes, 4 bits.
  - `alu_state_e`: IDLE/BUSY/DONE.
  - Helper constant `ALU_OP_IS_ITER` for codes 8–10.
- Sub-module `alu_muldiv_iter`, parametrised by W:
  - Inputs: start strobe, `op`, `a`, `b`.
  - Outputs: `lo`, `hi`, `dbz`, `done`.
  - Contains the W-step counter plus the shift-add and restoring-divide datapath.
  - Included only under `ALU_SEQ_MULDIV_EN`.
- Top level holds the FSM, the single-cycle datapath, output registers and flags.

## Test plan
- W=8, ADD with `a=200`, `b=100`, `out_ready=1`:
  - Expect `out_valid` 1 cycle after accept, with `alu_o=44`, `cout=1`, `zero=0`.
- SUB with `a=5`, `b=5`, then SUB with `a=3`, `b=7`:
  - First: `alu_o=0`, `zero=1`, `cout=0`.
  - Second: `alu_o=252`, `cout=1`.
- MULU with `a=255`, `b=255`:
  - `out_valid` exactly 9 cycles after accept; `alu_hi=254`, `alu_o=1`.
  - `in_ready=0` throughout.
- DIVU with `a=100`, `b=7` → `alu_o=14`. REMU with the same operands → `alu_o=2`.
  - DIVU with `a=9`, `b=0` → `alu_o=255`, `err=1`. REMU with `a=9`, `b=0` → `alu_o=9`, `err=1`.
- Backpressure and reset:
  - Hold `out_ready=0` for 5 cycles in DONE: outputs stay stable and no new op is accepted.
  - Assert `rst` on the 4th BUSY cycle of a MULU: all outputs are 0 next cycle, and `in_ready=1` the cycle after `rst` falls.
- Illegal `alu_ctrl=3` → `err=1`, `alu_o=0`, `zero=1`.
  - With `ALU_SEQ_MULDIV_EN` undefined, `alu_ctrl=8` gives the same response at 1-cycle latency.
  - Finish with 1000 random legal ops checked against a reference model; zero mismatches.
